// File: rtl/pi_link_deframer.sv
// Pi GPIO link deframer: syncs strobe/state/data, packs audio bytes into R/L pairs.
// Optional DEFERR_STATS_EN adds err_count/frame_count diagnostics.
module pi_link_deframer #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023,
  parameter int REQ_THRESH  = 64,
  parameter int LEVEL_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               link_clk,
  input  logic [1:0]         link_state,
  input  logic [7:0]         link_data,
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic [23:0]        sample_r,
  output logic [23:0]        sample_l,
  output logic               sample_wr,
  output logic               rx_req,
  output logic               frame_err
`ifdef DEFERR_STATS_EN
  ,
  output logic [15:0]        err_count,
  output logic [15:0]        frame_count
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
  localparam logic [LEVEL_W:0] THR = (LEVEL_W + 1)'(REQ_THRESH);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    COMMIT
  } state_t;

  logic [SYNC_STAGES-1:0]      clk_sync;
  logic [SYNC_STAGES-1:0][1:0] st_sync;
  logic [SYNC_STAGES-1:0][7:0] dat_sync;
  logic                        clk_dly;

  logic       clk_s;
  logic [1:0] st_s;
  logic [7:0] dat_s;
  logic       strobe;
  logic       audio;
  logic       cap;

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] sh_r;
  logic [15:0] sh_l;
  logic [TW-1:0] tmo;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign st_s   = st_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign strobe = clk_s & ~clk_dly;
  assign audio  = (st_s == 2'b11);
  assign cap    = strobe & audio;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '0;
      st_sync  <= '0;
      dat_sync <= '0;
      clk_dly  <= 1'b0;
    end else begin
      clk_sync[0] <= link_clk;
      st_sync[0]  <= link_state;
      dat_sync[0] <= link_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i] <= clk_sync[i-1];
        st_sync[i]  <= st_sync[i-1];
        dat_sync[i] <= dat_sync[i-1];
      end
      clk_dly <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      sh_r      <= '0;
      sh_l      <= '0;
      tmo       <= '0;
      sample_r  <= '0;
      sample_l  <= '0;
      sample_wr <= 1'b0;
      frame_err <= 1'b0;
      rx_req    <= 1'b0;
    end else begin
      sample_wr <= 1'b0;
      frame_err <= 1'b0;
      rx_req    <= ({1'b0, fifo_level} < THR);
      if (cap)
        tmo <= '0;
      else if (tmo != TMO_MAX)
        tmo <= tmo + 1'b1;
      unique case (state)
        IDLE: begin
          if (cap) begin
            sh_r[15:8] <= dat_s;
            idx        <= 2'd1;
            state      <= COLLECT;
          end
        end
        COLLECT: begin
          // a state change or timeout beats a simultaneous byte
          if (!audio || tmo == TMO_MAX) begin
            frame_err <= 1'b1;
            idx       <= 2'd0;
            state     <= IDLE;
          end else if (cap) begin
            unique case (idx)
              2'd1: sh_r[7:0]  <= dat_s;
              2'd2: sh_l[15:8] <= dat_s;
              default: begin
                sh_l[7:0] <= dat_s;
                state     <= COMMIT;
              end
            endcase
            idx <= idx + 2'd1;
          end
        end
        default: begin
          sample_r  <= {sh_r, 8'h00};
          sample_l  <= {sh_l, 8'h00};
          sample_wr <= 1'b1;
          idx       <= 2'd0;
          state     <= IDLE;
          if (cap) begin
            sh_r[15:8] <= dat_s;
            idx        <= 2'd1;
            state      <= COLLECT;
          end
        end
      endcase
    end
  end

`ifdef DEFERR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      if (frame_err && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      if (sample_wr)
        frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pi_link_deframer.md
# pi_link_deframer

Receive-side deframer for the Raspberry Pi GPIO link in the sclk domain. It synchronises the Pi strobe (CLOCK), link state (STATE1:0) and data byte (GPIO15..8), then assembles audio-state bytes into right/left 24-bit sample pairs. Each complete pair is presented with a single-cycle write strobe to the audio FIFO pair that feeds spdif_core. It also produces the FPGA_RX_REQ flow-control level from the FIFO fill count.

## Interface
Parameters:
- SYNC_STAGES, 2: flip-flop stages on strobe, state and data.
- TIMEOUT, 1023: clk cycles allowed between bytes of one frame before the frame is dropped.
- REQ_THRESH, 64: FIFO fill level below which more audio is requested.
- LEVEL_W, 8: width of the FIFO fill count.

Ports:
- clk  in  1  sclk-domain clock. One clock only.
- rst  in  1  synchronous, active-high reset.
- link_clk  in  1  Pi byte strobe (CLOCK), asynchronous.
- link_state  in  2  {STATE1, STATE0}, asynchronous; value 3 = audio transfer.
- link_data  in  8  {GPIO15..GPIO8}, asynchronous.
- fifo_level  in  LEVEL_W  audio FIFO used-words count.
- sample_r  out  24  right sample (goes to the right FIFO).
- sample_l  out  24  left sample.
- sample_wr  out  1  one-cycle write strobe for both FIFOs.
- rx_req  out  1  drives FPGA_RX_REQ.
- frame_err  out  1  one-cycle pulse when a partial frame is dropped.

## Operation
- **Synchronisation.** link_clk, link_state and link_data each pass through SYNC_STAGES flops. A rising edge is detected on the synchronised strobe by comparing it with one extra delayed copy.
- **Byte capture.** A byte is captured only on a detected edge while the synchronised link_state == 3.
- **State machine.** Three states: IDLE, COLLECT, COMMIT.
  - IDLE: byte index 0. The first audio byte moves the FSM to COLLECT.
  - COLLECT, index 0..3: bytes map to R[23:16], R[15:8], L[23:16], L[15:8]. Bits [7:0] of both samples are forced to 0. Capturing byte index 3 moves the FSM to COMMIT.
  - COMMIT: lasts one cycle. sample_r and sample_l are loaded from the shadow registers, sample_wr = 1, then the FSM returns to IDLE.
- **Sample hold.** sample_r and sample_l hold their values until the next COMMIT. Shadow registers are not visible on the outputs.
- **Dropped frames.** A frame is dropped, frame_err is pulsed, and the FSM goes to IDLE if either of these happens in COLLECT:
  - link_state leaves 3 while index is 1..3;
  - the inter-byte counter reaches TIMEOUT.
- **Timeout counter.** Reset on every captured byte. Saturates; it does not wrap.
- **Simultaneous events.** If a byte edge and a state change arrive in the same cycle, the state change wins: the byte is ignored and the drop rule applies.
- **Back-to-back frames.** An edge arriving during COMMIT is captured as index 0 of the next frame.
- **Flow control.** rx_req is registered: 1 when fifo_level < REQ_THRESH, else 0. Equality gives 0.
- **FIFO full.** Not detected here. The FIFO drops on full and rx_req throttles the Pi.

## Timing
- **Reset values.** sample_r = 0, sample_l = 0, sample_wr = 0, rx_req = 0, frame_err = 0. FSM = IDLE, index 0, timeout counter 0, synchronisers cleared.
- **Reset during a frame.** Discards the frame, with no sample_wr and no frame_err.
- **Capture latency.** A link_clk rising edge is captured SYNC_STAGES+1 clk cycles later. The Pi must hold link_data and link_state stable for at least SYNC_STAGES+2 clk cycles after each strobe edge.
- **Write latency.** sample_wr is asserted exactly 1 cycle after the 4th byte is captured. Minimum spacing between sample_wr pulses is 5 cycles.
- **Flow-control latency.** rx_req lags fifo_level by 1 cycle.
- **Pulse widths.** frame_err and sample_wr are always exactly 1 cycle.

## Configuration
- **DEFERR_STATS_EN defined.** Adds two outputs:
  - err_count (16-bit): saturating count of frame_err pulses.
  - frame_count (16-bit): wrapping count of sample_wr pulses.
  
  Both are cleared by rst and wired to the LEDs for link diagnostics.
- **DEFERR_STATS_EN not defined.** Both ports and both counters are absent. All other behaviour is identical.

## Test plan
- **Single frame.** State 3, bytes 0x12, 0x34, 0x56, 0x78 on four strobes → one sample_wr pulse, 1 cycle after the 4th capture, with sample_r = 0x123400 and sample_l = 0x567800.
- **Back-to-back frames.** 8 bytes spaced 5 cycles apart → exactly two sample_wr pulses, with correct data in each, and no frame_err.
- **State drop mid-frame.** 2 bytes, then link_state → 0 → frame_err pulse, no sample_wr, and sample_r/sample_l keep their previous values. The next 4-byte frame is received correctly.
- **Timeout.** 3 bytes, then no strobe for TIMEOUT+5 cycles → frame_err. A following full frame commits correctly.
- **Flow control.** fifo_level sweeps 70 → 63 → 64 → rx_req = 0, then 1, then 0, each 1 cycle after the level change.
- **Reset mid-frame.** rst after 2 bytes → all outputs return to 0, no pulses. With DEFERR_STATS_EN defined, err_count stays 0.
